// File: rtl/alarma_timbre.sv
// Alarm ringing controller: edge-detects the alarm match flag and the stop/snooze
// buttons, then drives a blinking buzzer/LED with ring timeout and limited snoozes.
module alarma_timbre #(
  parameter int HALF_SEC_CYCLES = 50_000_000,
  parameter int RING_SECONDS    = 60,
  parameter int SNOOZE_SECONDS  = 300,
  parameter int MAX_SNOOZE      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] Flag_Pico,
  input  logic       Apagar,
  input  logic       Posponer,
  output logic       Timbre,
  output logic       Led_Alarma,
  output logic       Alarma_Activa,
  output logic [1:0] Estado_Alarma,
  output logic [3:0] Num_Pospuesto
);

  localparam int HW        = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
  localparam int TICKS_MAX = 2 * ((RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS);
  localparam int TW        = $clog2(TICKS_MAX + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      num_reg, num_next;
  logic [HW-1:0]   half_cnt_reg;
  logic [TW-1:0]   tick_cnt_reg;
  logic            blink_reg;
  logic            flag_prev_reg, apagar_prev_reg, posponer_prev_reg;
  logic            enter;

  logic flag_nz, flag_ev, apagar_ev, posponer_ev;
  logic half_tick, ring_done, snooze_done;

  assign flag_nz     = |Flag_Pico;
  assign flag_ev     = flag_nz  & ~flag_prev_reg;
  assign apagar_ev   = Apagar   & ~apagar_prev_reg;
  assign posponer_ev = Posponer & ~posponer_prev_reg;

  assign half_tick   = (half_cnt_reg == HW'(HALF_SEC_CYCLES - 1));
  assign ring_done   = half_tick && (tick_cnt_reg == TW'(2 * RING_SECONDS - 1));
  assign snooze_done = half_tick && (tick_cnt_reg == TW'(2 * SNOOZE_SECONDS - 1));

  // Previous samples reset high so inputs already asserted at release do not fire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_prev_reg     <= 1'b1;
      apagar_prev_reg   <= 1'b1;
      posponer_prev_reg <= 1'b1;
    end else begin
      flag_prev_reg     <= flag_nz;
      apagar_prev_reg   <= Apagar;
      posponer_prev_reg <= Posponer;
    end
  end

  always_comb begin
    state_next = state_reg;
    num_next   = num_reg;
    enter      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (flag_ev) begin
          state_next = RING;
          num_next   = 4'd0;
          enter      = 1'b1;
        end
      end
      RING: begin
        if (apagar_ev) begin
          state_next = IDLE;
          num_next   = 4'd0;
          enter      = 1'b1;
        end else if (posponer_ev && (num_reg < 4'(MAX_SNOOZE))) begin
          state_next = SNOOZE;
          num_next   = num_reg + 4'd1;
          enter      = 1'b1;
        end else if (flag_ev) begin
          state_next = RING;
          enter      = 1'b1;
        end else if (ring_done) begin
          state_next = IDLE;
          num_next   = 4'd0;
          enter      = 1'b1;
        end
      end
      SNOOZE: begin
        if (apagar_ev) begin
          state_next = IDLE;
          num_next   = 4'd0;
          enter      = 1'b1;
        end else if (flag_ev || snooze_done) begin
          state_next = RING;
          enter      = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        num_next   = 4'd0;
        enter      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      num_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      num_reg   <= num_next;
    end
  end

  // Timebase restarts on every state entry, including a RING re-entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      half_cnt_reg <= '0;
      tick_cnt_reg <= '0;
      blink_reg    <= 1'b0;
    end else if (enter) begin
      half_cnt_reg <= '0;
      tick_cnt_reg <= '0;
      blink_reg    <= 1'b1;
    end else if (state_reg == IDLE) begin
      half_cnt_reg <= '0;
      tick_cnt_reg <= '0;
    end else if (half_tick) begin
      half_cnt_reg <= '0;
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
      blink_reg    <= ~blink_reg;
    end else begin
      half_cnt_reg <= half_cnt_reg + HW'(1);
    end
  end

  assign Alarma_Activa = (state_reg != IDLE);
  assign Timbre        = (state_reg == RING) & blink_reg;
  assign Led_Alarma    = (state_reg != IDLE) & blink_reg;
  assign Estado_Alarma = state_reg;
  assign Num_Pospuesto = num_reg;

endmodule

// File: tb/tb_alarma_timbre.sv
// Self-checking bench for alarma_timbre: directed scenarios plus random stimulus
// compared against a cycle-count based behavioural model.
module tb_alarma_timbre;

  localparam int H = 4;
  localparam int R = 3;
  localparam int S = 2;
  localparam int M = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] Flag_Pico = 8'd0;
  logic       Apagar = 1'b0;
  logic       Posponer = 1'b0;
  logic       Timbre, Led_Alarma, Alarma_Activa;
  logic [1:0] Estado_Alarma;
  logic [3:0] Num_Pospuesto;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: state code, snoozes taken, cycles elapsed since state entry, previous samples.
  int m_state = 0;
  int m_num   = 0;
  int m_el    = 0;
  bit m_pf = 1'b1, m_pa = 1'b1, m_pp = 1'b1;

  alarma_timbre #(
    .HALF_SEC_CYCLES(H), .RING_SECONDS(R), .SNOOZE_SECONDS(S), .MAX_SNOOZE(M)
  ) dut (
    .clk(clk), .reset(reset), .Flag_Pico(Flag_Pico), .Apagar(Apagar), .Posponer(Posponer),
    .Timbre(Timbre), .Led_Alarma(Led_Alarma), .Alarma_Activa(Alarma_Activa),
    .Estado_Alarma(Estado_Alarma), .Num_Pospuesto(Num_Pospuesto)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_state = 0; m_num = 0; m_el = 0;
    m_pf = 1'b1; m_pa = 1'b1; m_pp = 1'b1;
  endfunction

  function automatic void model_step(input bit f, input bit a, input bit p);
    bit fe, ae, pe;
    fe = f & !m_pf; ae = a & !m_pa; pe = p & !m_pp;
    m_pf = f; m_pa = a; m_pp = p;
    case (m_state)
      0: if (fe) begin m_state = 1; m_num = 0; m_el = 0; end
      1: begin
        if (ae) begin m_state = 0; m_num = 0; m_el = 0; end
        else if (pe && m_num < M) begin m_state = 2; m_num++; m_el = 0; end
        else if (fe) m_el = 0;
        else if (m_el + 1 == 2 * R * H) begin m_state = 0; m_num = 0; m_el = 0; end
        else m_el++;
      end
      default: begin
        if (ae) begin m_state = 0; m_num = 0; m_el = 0; end
        else if (fe || (m_el + 1 == 2 * S * H)) begin m_state = 1; m_el = 0; end
        else m_el++;
      end
    endcase
  endfunction

  function automatic logic [8:0] exp_vec();
    bit bl, act;
    bl  = ((m_el / H) % 2) == 0;
    act = (m_state != 0);
    return {2'(m_state), 4'(m_num), act, act & bl, (m_state == 1) & bl};
  endfunction

  function automatic logic [8:0] dut_vec();
    return {Estado_Alarma, Num_Pospuesto, Alarma_Activa, Led_Alarma, Timbre};
  endfunction

  task automatic cycle(input logic [7:0] f, input logic a, input logic p);
    Flag_Pico = f; Apagar = a; Posponer = p;
    @(posedge clk);
    model_step(f != 8'd0, a, p);
    #1;
  endtask

  task automatic go_idle();
    cycle(8'd0, 1'b1, 1'b0);
    cycle(8'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== 9'd0) begin
      n_bad++; $display("FAIL reset_state: got %b expected %b", dut_vec(), 9'd0);
    end
    reset = 1'b0;
    cycle(8'd0, 1'b0, 1'b0);
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_release: got %b expected %b", dut_vec(), exp_vec());
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_ring();
    int n = 0;
    go_idle();
    cycle(8'h01, 1'b0, 1'b0);
    n_cmp++;
    if (Estado_Alarma !== 2'd1) begin
      n_bad++; $display("FAIL ring_entry: got %0d expected 1", Estado_Alarma);
    end
    while (Estado_Alarma === 2'd1 && n < 40) begin
      n_cmp++;
      if (dut_vec() !== exp_vec() || Timbre !== (((n / H) % 2) == 0)) begin
        n_bad++; $display("FAIL ring_cycle%0d: got %b expected %b", n, dut_vec(), exp_vec());
      end
      n++;
      cycle(8'h01, 1'b0, 1'b0);
    end
    n_cmp++;
    if (n !== 2 * R * H) begin
      n_bad++; $display("FAIL ring_length: got %0d expected %0d", n, 2 * R * H);
    end
    repeat (8) begin
      cycle(8'h01, 1'b0, 1'b0);
      n_cmp++;
      if (Estado_Alarma !== 2'd0 || Timbre !== 1'b0 || dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ring_no_retrigger: got %b expected %b", dut_vec(), exp_vec());
      end
    end
    $display("test_basic_ring done, ring cycles %0d", n);
  endtask

  task automatic test_stop();
    go_idle();
    repeat (5) cycle(8'h01, 1'b0, 1'b0);
    cycle(8'h01, 1'b1, 1'b0);
    n_cmp++;
    if (Estado_Alarma !== 2'd0 || Timbre !== 1'b0 || Num_Pospuesto !== 4'd0) begin
      n_bad++; $display("FAIL stop: got %b expected state0 timbre0 num0", dut_vec());
    end
    repeat (3) begin
      cycle(8'h01, 1'b0, 1'b0);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL stop_hold: got %b expected %b", dut_vec(), exp_vec());
      end
    end
    $display("test_stop done");
  endtask

  task automatic test_snooze_limit();
    int n;
    go_idle();
    cycle(8'h01, 1'b0, 1'b0);
    for (int k = 1; k <= M; k++) begin
      cycle(8'h00, 1'b0, 1'b1);
      n_cmp++;
      if (Estado_Alarma !== 2'd2 || Num_Pospuesto !== 4'(k)) begin
        n_bad++; $display("FAIL snooze_enter%0d: got %b expected state2 num%0d", k, dut_vec(), k);
      end
      n = 0;
      while (Estado_Alarma === 2'd2 && n < 40) begin
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
          n_bad++; $display("FAIL snooze_cycle%0d: got %b expected %b", n, dut_vec(), exp_vec());
        end
        n++;
        cycle(8'h00, 1'b0, 1'b0);
      end
      n_cmp++;
      if (n !== 2 * S * H || Estado_Alarma !== 2'd1) begin
        n_bad++; $display("FAIL snooze_length%0d: got %0d state %0d expected %0d state 1", k, n, Estado_Alarma, 2 * S * H);
      end
    end
    cycle(8'h00, 1'b0, 1'b1);
    n_cmp++;
    if (Estado_Alarma !== 2'd1 || Num_Pospuesto !== 4'(M)) begin
      n_bad++; $display("FAIL snooze_limit: got %b expected state1 num%0d", dut_vec(), M);
    end
    n = 0;
    while (Estado_Alarma === 2'd1 && n < 40) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL limit_ring%0d: got %b expected %b", n, dut_vec(), exp_vec());
      end
      n++;
      cycle(8'h00, 1'b0, 1'b0);
    end
    n_cmp++;
    if (n !== 2 * R * H - 1 || Estado_Alarma !== 2'd0 || Num_Pospuesto !== 4'd0) begin
      n_bad++; $display("FAIL limit_timeout: got %0d cycles %b expected %0d cycles idle", n, dut_vec(), 2 * R * H - 1);
    end
    $display("test_snooze_limit done");
  endtask

  task automatic test_simultaneous();
    go_idle();
    cycle(8'h01, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b1, 1'b1);
    n_cmp++;
    if (Estado_Alarma !== 2'd0 || Num_Pospuesto !== 4'd0 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL simultaneous: got %b expected %b", dut_vec(), exp_vec());
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_reset_mid();
    go_idle();
    repeat (3) cycle(8'h01, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_vec() !== 9'd0) begin
      n_bad++; $display("FAIL reset_mid_async: got %b expected %b", dut_vec(), 9'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cycle(8'h01, 1'b0, 1'b0);
    n_cmp++;
    if (Estado_Alarma !== 2'd0) begin
      n_bad++; $display("FAIL reset_flag_held: got state %0d expected 0", Estado_Alarma);
    end
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h01, 1'b0, 1'b0);
    n_cmp++;
    if (Estado_Alarma !== 2'd1 || dut_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_rearm: got %b expected %b", dut_vec(), exp_vec());
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_flag_in_snooze();
    int n = 0;
    go_idle();
    cycle(8'h01, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b1);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h00, 1'b0, 1'b0);
    cycle(8'h80, 1'b0, 1'b0);
    n_cmp++;
    if (Estado_Alarma !== 2'd1 || Num_Pospuesto !== 4'd1) begin
      n_bad++; $display("FAIL snooze_flag: got %b expected state1 num1", dut_vec());
    end
    while (Estado_Alarma === 2'd1 && n < 40) begin
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL snooze_flag_ring%0d: got %b expected %b", n, dut_vec(), exp_vec());
      end
      n++;
      cycle(8'h80, 1'b0, 1'b0);
    end
    n_cmp++;
    if (n !== 2 * R * H) begin
      n_bad++; $display("FAIL snooze_flag_length: got %0d expected %0d", n, 2 * R * H);
    end
    $display("test_flag_in_snooze done");
  endtask

  task automatic test_random();
    logic [7:0] f;
    logic a, p;
    go_idle();
    for (int i = 0; i < 600; i++) begin
      f = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      a = ($urandom_range(0, 39) == 0);
      p = ($urandom_range(0, 7) == 0);
      cycle(f, a, p);
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_basic_ring();
    test_stop();
    test_snooze_limit();
    test_simultaneous();
    test_reset_mid();
    test_flag_in_snooze();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
